// File: rtl/fmpadding_cfg_axil_master.sv
// AXI-Lite initiator that programs the feature-map padding register slave.
// Takes one register read/write command at a time, runs it as a single
// AXI-Lite transaction and hands back the read data and response code.
module fmpadding_cfg_axil_master #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 32
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,

  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr,
  input  logic [ADDR_BITS-1:0]   cmd_addr,
  input  logic [DATA_BITS-1:0]   cmd_wdata,

  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_BITS-1:0]   rsp_rdata,
  output logic [1:0]             rsp_resp,
  output logic                   err,

  output logic                   m_axilite_AWVALID,
  input  logic                   m_axilite_AWREADY,
  output logic [ADDR_BITS-1:0]   m_axilite_AWADDR,

  output logic                   m_axilite_WVALID,
  input  logic                   m_axilite_WREADY,
  output logic [DATA_BITS-1:0]   m_axilite_WDATA,
  output logic [DATA_BITS/8-1:0] m_axilite_WSTRB,

  input  logic                   m_axilite_BVALID,
  output logic                   m_axilite_BREADY,
  input  logic [1:0]             m_axilite_BRESP,

  output logic                   m_axilite_ARVALID,
  input  logic                   m_axilite_ARREADY,
  output logic [ADDR_BITS-1:0]   m_axilite_ARADDR,

  input  logic                   m_axilite_RVALID,
  output logic                   m_axilite_RREADY,
  input  logic [DATA_BITS-1:0]   m_axilite_RDATA,
  input  logic [1:0]             m_axilite_RRESP
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] WRESP = 3'd2;
  localparam logic [2:0] READ  = 3'd3;
  localparam logic [2:0] RDATA = 3'd4;
  localparam logic [2:0] RESP  = 3'd5;

  logic [2:0]           state_q,     state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 awvalid_q,   awvalid_d;
  logic                 wvalid_q,    wvalid_d;
  logic                 bready_q,    bready_d;
  logic                 arvalid_q,   arvalid_d;
  logic                 rready_q,    rready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_BITS-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]           rsp_resp_q,  rsp_resp_d;
  logic                 err_q,       err_d;
  logic [ADDR_BITS-1:0] awaddr_q,    awaddr_d;
  logic [ADDR_BITS-1:0] araddr_q,    araddr_d;
  logic [DATA_BITS-1:0] wdata_q,     wdata_d;

  // Next-state logic: walks one command through its AXI-Lite channels and parks the result until consumed.
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    err_d       = err_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_wr) begin
            state_d   = WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
          end else begin
            state_d   = READ;
            arvalid_d = 1'b1;
            araddr_d  = cmd_addr;
          end
        end
      end

      WRITE: begin
        if (awvalid_q && m_axilite_AWREADY) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && m_axilite_WREADY) begin
          wvalid_d = 1'b0;
        end
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WRESP;
          bready_d = 1'b1;
        end
      end

      WRESP: begin
        if (m_axilite_BVALID && bready_q) begin
          bready_d    = 1'b0;
          rsp_resp_d  = m_axilite_BRESP;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          err_d       = err_q | (m_axilite_BRESP != 2'b00);
          state_d     = RESP;
        end
      end

      READ: begin
        if (arvalid_q && m_axilite_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end

      RDATA: begin
        if (m_axilite_RVALID && rready_q) begin
          rready_d    = 1'b0;
          rsp_resp_d  = m_axilite_RRESP;
          rsp_rdata_d = m_axilite_RDATA;
          rsp_valid_d = 1'b1;
          err_d       = err_q | (m_axilite_RRESP != 2'b00);
          state_d     = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase

    // Registered so it only rises once the FSM is back in IDLE.
    cmd_ready_d = (state_d == IDLE);
  end

  // State registers; reset abandons any transaction in flight without a response.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      err_q       <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      err_q       <= err_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign cmd_ready         = cmd_ready_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_rdata         = rsp_rdata_q;
  assign rsp_resp          = rsp_resp_q;
  assign err               = err_q;
  assign m_axilite_AWVALID = awvalid_q;
  assign m_axilite_AWADDR  = awaddr_q;
  assign m_axilite_WVALID  = wvalid_q;
  assign m_axilite_WDATA   = wdata_q;
  assign m_axilite_WSTRB   = '1;
  assign m_axilite_BREADY  = bready_q;
  assign m_axilite_ARVALID = arvalid_q;
  assign m_axilite_ARADDR  = araddr_q;
  assign m_axilite_RREADY  = rready_q;

endmodule

// File: tb/tb_fmpadding_cfg_axil_master.sv
// Directed bench for fmpadding_cfg_axil_master: a programmable-latency
// AXI-Lite slave model plus a table of commands with hand-computed results.
module tb_fmpadding_cfg_axil_master;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        err;
  logic        AWVALID, AWREADY;
  logic [4:0]  AWADDR;
  logic        WVALID, WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic        ARVALID, ARREADY;
  logic [4:0]  ARADDR;
  logic        RVALID, RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;

  fmpadding_cfg_axil_master #(.ADDR_BITS(5), .DATA_BITS(32)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .err(err),
    .m_axilite_AWVALID(AWVALID), .m_axilite_AWREADY(AWREADY), .m_axilite_AWADDR(AWADDR),
    .m_axilite_WVALID(WVALID), .m_axilite_WREADY(WREADY), .m_axilite_WDATA(WDATA),
    .m_axilite_WSTRB(WSTRB),
    .m_axilite_BVALID(BVALID), .m_axilite_BREADY(BREADY), .m_axilite_BRESP(BRESP),
    .m_axilite_ARVALID(ARVALID), .m_axilite_ARREADY(ARREADY), .m_axilite_ARADDR(ARADDR),
    .m_axilite_RVALID(RVALID), .m_axilite_RREADY(RREADY), .m_axilite_RDATA(RDATA),
    .m_axilite_RRESP(RRESP)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Slave model configuration, set per vector.
  int          awDelayCfg = 0;
  int          wDelayCfg  = 0;
  int          bDelayCfg  = 0;
  int          arDelayCfg = 0;
  int          rDelayCfg  = 0;
  logic [1:0]  bRespCfg   = 2'b00;
  logic [1:0]  rRespCfg   = 2'b00;
  logic [31:0] rDataCfg   = 32'h0;

  int   awCnt, wCnt, arCnt, bCnt, rCnt;
  logic awGot, wGot, bPend, rPend;

  assign AWREADY = AWVALID && (awCnt >= awDelayCfg);
  assign WREADY  = WVALID  && (wCnt  >= wDelayCfg);
  assign ARREADY = ARVALID && (arCnt >= arDelayCfg);
  assign BVALID  = bPend && (bCnt >= bDelayCfg);
  assign RVALID  = rPend && (rCnt >= rDelayCfg);
  assign BRESP   = bRespCfg;
  assign RRESP   = rRespCfg;
  assign RDATA   = rDataCfg;

  // Slave model: each READY waits its configured number of VALID cycles; B/R follow after their delay.
  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      awCnt <= 0; wCnt <= 0; arCnt <= 0; bCnt <= 0; rCnt <= 0;
      awGot <= 1'b0; wGot <= 1'b0; bPend <= 1'b0; rPend <= 1'b0;
    end else begin
      awCnt <= (AWVALID && !AWREADY) ? awCnt + 1 : 0;
      wCnt  <= (WVALID  && !WREADY)  ? wCnt + 1  : 0;
      arCnt <= (ARVALID && !ARREADY) ? arCnt + 1 : 0;
      if (bPend) begin
        if (BVALID && BREADY) begin
          bPend <= 1'b0;
          bCnt  <= 0;
        end else if (!BVALID) begin
          bCnt <= bCnt + 1;
        end
      end else if ((awGot || (AWVALID && AWREADY)) && (wGot || (WVALID && WREADY))) begin
        bPend <= 1'b1;
        bCnt  <= 0;
        awGot <= 1'b0;
        wGot  <= 1'b0;
      end else begin
        if (AWVALID && AWREADY) awGot <= 1'b1;
        if (WVALID && WREADY)   wGot  <= 1'b1;
      end
      if (rPend) begin
        if (RVALID && RREADY) begin
          rPend <= 1'b0;
          rCnt  <= 0;
        end else if (!RVALID) begin
          rCnt <= rCnt + 1;
        end
      end else if (ARVALID && ARREADY) begin
        rPend <= 1'b1;
        rCnt  <= 0;
      end
    end
  end

  // Bus monitor totals; tests look at differences across a transaction.
  int          awHighTot = 0, wHighTot = 0, arHighTot = 0;
  int          awHsTot = 0, arHsTot = 0, bAccTot = 0;
  int          unstableTot = 0;
  logic [4:0]  awAddrSeen = '0, arAddrSeen = '0;
  logic [31:0] wDataSeen = '0;
  logic        awPrevPend = 0, wPrevPend = 0, arPrevPend = 0;
  logic [4:0]  awPrevAddr = '0, arPrevAddr = '0;
  logic [31:0] wPrevData = '0;

  // Counts VALID-high cycles and handshakes, and flags any VALID that drops or changes payload before READY.
  always @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      awPrevPend = 0; wPrevPend = 0; arPrevPend = 0;
    end else begin
      if (AWVALID) awHighTot++;
      if (WVALID)  wHighTot++;
      if (ARVALID) arHighTot++;
      if (AWVALID && AWREADY) begin awHsTot++; awAddrSeen = AWADDR; end
      if (WVALID && WREADY) wDataSeen = WDATA;
      if (ARVALID && ARREADY) begin arHsTot++; arAddrSeen = ARADDR; end
      if (BVALID && BREADY) bAccTot++;
      if (awPrevPend && (!AWVALID || AWADDR !== awPrevAddr)) unstableTot++;
      if (wPrevPend  && (!WVALID  || WDATA  !== wPrevData))  unstableTot++;
      if (arPrevPend && (!ARVALID || ARADDR !== arPrevAddr)) unstableTot++;
      awPrevPend = AWVALID && !AWREADY; awPrevAddr = AWADDR;
      wPrevPend  = WVALID  && !WREADY;  wPrevData  = WDATA;
      arPrevPend = ARVALID && !ARREADY; arPrevAddr = ARADDR;
    end
  end

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    int          awDelay, wDelay, bDelay, arDelay, rDelay;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [31:0] expRdata;
    logic [1:0]  expResp;
    logic        expErr;
    int          expAwCycles, expWCycles, expArCycles;
  } vec_t;

  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;
  int   snapAw, snapW, snapAr, snapB, snapAwHs, snapArHs;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic sendCmd(input logic wr, input logic [4:0] addr, input logic [31:0] wdata);
    int n;
    @(negedge ap_clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 100) checkOutput("cmdAcceptTimeout", 32'd1, 32'd0);
    @(posedge ap_clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitRsp();
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 200) checkOutput("rspTimeout", 32'd1, 32'd0);
  endtask

  task automatic consumeRsp();
    @(negedge ap_clk);
    rsp_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput("rspDropAfterHs", {31'd0, rsp_valid}, 32'd0);
    checkOutput("cmdReadyAfterHs", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    awDelayCfg = v.awDelay; wDelayCfg = v.wDelay; bDelayCfg = v.bDelay;
    arDelayCfg = v.arDelay; rDelayCfg = v.rDelay;
    bRespCfg = v.bresp; rRespCfg = v.rresp; rDataCfg = v.rdata;
    snapAw = awHighTot; snapW = wHighTot; snapAr = arHighTot;
    snapB = bAccTot; snapAwHs = awHsTot; snapArHs = arHsTot;
    sendCmd(v.wr, v.addr, v.wdata);
    checkOutput("validOneCycleAfterCmd", {29'd0, AWVALID, WVALID, ARVALID},
                v.wr ? 32'd6 : 32'd1);
    waitRsp();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 5'h04, 32'h0000_0003, 0, 0, 2, 0, 0, 2'b00, 2'b00, 32'h0,
                32'h0, 2'b00, 1'b0, 1, 1, 0};
    vecs[1] = '{1'b1, 5'h04, 32'h0000_0003, 0, 5, 0, 0, 0, 2'b00, 2'b00, 32'h0,
                32'h0, 2'b00, 1'b0, 1, 6, 0};
    vecs[2] = '{1'b0, 5'h10, 32'h0, 0, 0, 0, 3, 1, 2'b00, 2'b00, 32'hDEAD_BEEF,
                32'hDEAD_BEEF, 2'b00, 1'b0, 0, 0, 4};
    vecs[3] = '{1'b1, 5'h08, 32'h0000_0005, 2, 1, 0, 0, 0, 2'b10, 2'b00, 32'h0,
                32'h0, 2'b10, 1'b1, 3, 2, 0};
    vecs[4] = '{1'b0, 5'h0C, 32'h0, 0, 0, 0, 0, 2, 2'b00, 2'b00, 32'h1234_5678,
                32'h1234_5678, 2'b00, 1'b1, 0, 0, 1};
    vecs[5] = '{1'b0, 5'h1F, 32'h0, 0, 0, 0, 1, 0, 2'b00, 2'b11, 32'h0000_CAFE,
                32'h0000_CAFE, 2'b11, 1'b1, 0, 0, 2};

    ap_rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge ap_clk);

    // Reset state
    checkOutput("rstValids", {25'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY, cmd_ready, rsp_valid}, 32'd0);
    checkOutput("rstRspRdata", rsp_rdata, 32'd0);
    checkOutput("rstRspResp", {30'd0, rsp_resp}, 32'd0);
    checkOutput("rstErr", {31'd0, err}, 32'd0);
    checkOutput("rstAddrs", {22'd0, AWADDR, ARADDR}, 32'd0);
    checkOutput("rstWdata", WDATA, 32'd0);
    checkOutput("rstWstrb", {28'd0, WSTRB}, 32'hF);
    ap_rst_n = 1'b1;
    #1;
    checkOutput("cmdReadyBeforeEdge", {31'd0, cmd_ready}, 32'd0);
    @(posedge ap_clk);
    #1;
    checkOutput("cmdReadyFirstEdge", {31'd0, cmd_ready}, 32'd1);

    // Table-driven transactions
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].expRdata);
      checkOutput($sformatf("v%0d_resp", i), {30'd0, rsp_resp}, {30'd0, vecs[i].expResp});
      checkOutput($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].expErr});
      checkOutput($sformatf("v%0d_awCycles", i), awHighTot - snapAw, vecs[i].expAwCycles);
      checkOutput($sformatf("v%0d_wCycles", i), wHighTot - snapW, vecs[i].expWCycles);
      checkOutput($sformatf("v%0d_arCycles", i), arHighTot - snapAr, vecs[i].expArCycles);
      checkOutput($sformatf("v%0d_bAccepts", i), bAccTot - snapB, vecs[i].wr ? 32'd1 : 32'd0);
      if (vecs[i].wr) begin
        checkOutput($sformatf("v%0d_awAddr", i), {27'd0, awAddrSeen}, {27'd0, vecs[i].addr});
        checkOutput($sformatf("v%0d_wData", i), wDataSeen, vecs[i].wdata);
      end else begin
        checkOutput($sformatf("v%0d_arAddr", i), {27'd0, arAddrSeen}, {27'd0, vecs[i].addr});
      end
      consumeRsp();
    end

    // Response backpressure with a new command already waiting
    awDelayCfg = 0; wDelayCfg = 0; bDelayCfg = 0; arDelayCfg = 0; rDelayCfg = 0;
    rRespCfg = 2'b01; rDataCfg = 32'hA5A5_0001; bRespCfg = 2'b00;
    sendCmd(1'b0, 5'h14, 32'h0);
    waitRsp();
    begin
      int bad;
      bad = 0;
      snapAwHs = awHsTot; snapArHs = arHsTot; snapAw = awHighTot; snapAr = arHighTot;
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 5'h00; cmd_wdata = 32'h0000_0007;
      for (int k = 0; k < 10; k++) begin
        @(negedge ap_clk);
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_0001 || rsp_resp !== 2'b01 ||
            cmd_ready !== 1'b0)
          bad++;
      end
      checkOutput("stallRspStable", bad, 32'd0);
      checkOutput("stallNoNewIssue", (awHighTot - snapAw) + (arHighTot - snapAr), 32'd0);
      rsp_ready = 1'b1;
      @(posedge ap_clk);
      #1;
      rsp_ready = 1'b0;
      checkOutput("stallCmdReady", {30'd0, cmd_ready, rsp_valid}, 32'd2);
      @(posedge ap_clk);
      #1;
      checkOutput("stallNextAccepted", {30'd0, AWVALID, cmd_ready}, 32'd2);
      cmd_valid = 1'b0;
      @(negedge ap_clk);
      waitRsp();
      checkOutput("stallWriteResp", {rsp_rdata[29:0], rsp_resp}, 32'd0);
      checkOutput("stallWriteAddr", {27'd0, awAddrSeen}, 32'd0);
      consumeRsp();
    end

    // Reset while WVALID is still waiting for WREADY
    wDelayCfg = 20;
    sendCmd(1'b1, 5'h18, 32'h0000_00AA);
    repeat (3) @(negedge ap_clk);
    checkOutput("preRstWvalid", {31'd0, WVALID}, 32'd1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    checkOutput("asyncRstValids", {25'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY, cmd_ready, rsp_valid}, 32'd0);
    checkOutput("asyncRstErr", {31'd0, err}, 32'd0);
    @(posedge ap_clk);
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    wDelayCfg = 0;
    @(posedge ap_clk);
    #1;
    checkOutput("postRstCmdReady", {31'd0, cmd_ready}, 32'd1);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge ap_clk);
        if (rsp_valid !== 1'b0 || WVALID !== 1'b0 || AWVALID !== 1'b0) seen++;
      end
      checkOutput("postRstQuiet", seen, 32'd0);
    end

    // Clean read after reset leaves err low
    rRespCfg = 2'b00; rDataCfg = 32'h0000_0042; arDelayCfg = 0; rDelayCfg = 0;
    sendCmd(1'b0, 5'h04, 32'h0);
    waitRsp();
    checkOutput("postRstRead", rsp_rdata, 32'h0000_0042);
    checkOutput("postRstErr", {31'd0, err}, 32'd0);
    consumeRsp();

    checkOutput("payloadStable", unstableTot, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmpadding_cfg_axil_master.md
Name: fmpadding_cfg_axil_master

Overview:
AXI-Lite initiator that programs the feature-map padding block's AXI-Lite register slave, which holds the XON/XOFF/XEND/YON/YOFF/YEND registers.
- Accepts single-beat register read/write commands on a valid/ready command port.
- Issues each command as a protocol-correct AXI-Lite transaction and returns data and response on a valid/ready response port.
- Used by the on-chip sequencer or test harness to retune padding geometry at run time, one outstanding transaction at a time.

Parameters:
ADDR_BITS, 5, AXI-Lite address width; must match the slave (5 for the padding block).
DATA_BITS, 32, AXI-Lite data width; only 32 is supported.

Ports:
ap_clk  in  1  clock; all logic rising-edge.
ap_rst_n  in  1  reset, asynchronous, active-low.
cmd_valid  in  1  command valid.
cmd_ready  out  1  command accepted when valid&ready.
cmd_wr  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_BITS  register byte address.
cmd_wdata  in  32  write data; ignored for reads.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response consumed when valid&ready.
rsp_rdata  out  32  read data; 0 for writes.
rsp_resp  out  2  BRESP or RRESP of the transaction.
err  out  1  sticky: set by any nonzero BRESP/RRESP; cleared only by reset.
m_axilite_AWVALID/AWREADY/AWADDR  out/in/out  1/1/ADDR_BITS  write-address channel.
m_axilite_WVALID/WREADY/WDATA/WSTRB  out/in/out/out  1/1/32/4  write-data channel.
m_axilite_BVALID/BREADY/BRESP  in/out/in  1/1/2  write-response channel.
m_axilite_ARVALID/ARREADY/ARADDR  out/in/out  1/1/ADDR_BITS  read-address channel.
m_axilite_RVALID/RREADY/RDATA/RRESP  in/out/in/in  1/1/32/2  read-data channel.

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - All AXI VALID/READY outputs 0; cmd_ready 0; rsp_valid 0; rsp_rdata 0; rsp_resp 0; err 0.
  - AWADDR, ARADDR and WDATA are 0. WSTRB is constant 4'hF.
- cmd_ready is registered. It is 1 only in IDLE and rises on the first clock edge after reset release.
- States: IDLE, WRITE, WRESP, READ, RDATA, RESP.
- IDLE:
  - On cmd handshake, register addr/data and drop cmd_ready.
  - Write: go to WRITE with AWVALID=1 and WVALID=1 both driven from the next cycle (1-cycle latency).
  - Read: go to READ with ARVALID=1.
- WRITE:
  - AWVALID and WVALID each drop independently on their own handshake. Either order or the same cycle is legal.
  - Neither output may drop before its READY is sampled high. Address and data are stable while VALID is high.
  - Once both channels have handshaked, go to WRESP with BREADY=1.
- WRESP:
  - On BVALID&BREADY, capture BRESP into rsp_resp, set rsp_rdata=0, drop BREADY, go to RESP.
  - BREADY is never high outside WRESP.
- READ: on ARVALID&ARREADY, drop ARVALID and go to RDATA with RREADY=1.
- RDATA: on RVALID&RREADY, capture RDATA/RRESP, drop RREADY, go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_resp are held stable until rsp_ready.
  - On the handshake, drop rsp_valid, set cmd_ready=1, go to IDLE.
  - Minimum command-to-command spacing is therefore 1 idle cycle.
- err is set in the cycle a nonzero B/R response is captured.
- Exactly one transaction is outstanding; no AW/W/AR is issued while any transaction is unfinished.
- Slave backpressure of any length is tolerated; there is no timeout.
- Reset mid-transaction: all valids drop immediately, the transaction is abandoned and no response is emitted.
- Unknown cmd_addr values are forwarded unmodified; the slave decides the response.

Test Plan:
- Write addr 0x04 data 0x00000003, AWREADY/WREADY tied 1, BRESP=0 after 2 cycles -> AWVALID and WVALID high exactly 1 cycle, starting 1 cycle after the cmd handshake; rsp_valid with rsp_resp=0, rsp_rdata=0; err=0.
- Same write with WREADY delayed 5 cycles after AWREADY -> AWVALID drops after its handshake, WVALID stays high with WDATA=0x3 until its handshake; exactly one B accepted.
- Read addr 0x10, ARREADY after 3 cycles, RDATA=0xDEADBEEF, RRESP=0 -> rsp_rdata=0xDEADBEEF, rsp_resp=0; ARVALID held stable until the handshake.
- Write with BRESP=2'b10, then a read with RRESP=0 -> first rsp_resp=2, err=1 and still 1 after the second response; second rsp_resp=0.
- rsp_ready held low 10 cycles with cmd_valid high -> rsp fields stable, cmd_ready=0, no new AW/AR; command accepted the cycle after the rsp handshake.
- ap_rst_n asserted while WVALID is pending -> all valids and cmd_ready go 0 asynchronously; after release cmd_ready=1 within 1 cycle and no rsp_valid appears.
